vga_sync_decoder: RTL

//  Receive-side counterpart of the VGA sync generator. Consumes hsync/vsync/n_blank (same clock domain)
//  and recovers pixel_num/linea_num coordinates, plus a lock indication and timing-error flags.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_sync_decoder_if.sv | 28 ++
 rtl/vga_edge_detect.sv | 24 ++
 rtl/vga_sync_decoder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Raster timing shared by the VGA sync generator and the sync decoder.
// Also holds the decoder lock-state type and the counter wrap helper.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_SYNC_START = 491;
    localparam int unsigned V_SYNC_END   = 493;
    localparam int unsigned V_TOTAL      = 525;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] vga_cnt_t;

    typedef enum logic [1:0] {
        SEARCH,
        H_LOCK,
        LOCKED
    } vga_lock_state_t;

    function automatic vga_cnt_t wrap_inc(vga_cnt_t v, vga_cnt_t last);
        return (v == last) ? '0 : v + vga_cnt_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync input / recovered raster output bundle of the VGA sync decoder.
// master drives the syncs; slave is the decoder.
interface vga_sync_decoder_if;
    import vga_timing_pkg::*;

    logic     hsync;
    logic     vsync;
    logic     n_blank;
    vga_cnt_t pixel_num;
    vga_cnt_t linea_num;
    logic     pixel_valid;
    logic     locked;
    logic     frame_start;
    logic     sync_error;

    modport master (
        output hsync, vsync, n_blank,
        input  pixel_num, linea_num, pixel_valid,
        input  locked, frame_start, sync_error
    );

    modport slave (
        input  hsync, vsync, n_blank,
        output pixel_num, linea_num, pixel_valid,
        output locked, frame_start, sync_error
    );

endinterface

// File: rtl/vga_edge_detect.sv
// Registers a sync line (idle high) and flags rise/fall of the
// current sample against the previous one.
module vga_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;
    assign fall = ~d & prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers raster coordinates, lock and timing-error flags from
// hsync/vsync/n_blank of a VGA sync generator in the same clock domain.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_SYNC_START = vga_timing_pkg::H_SYNC_START,
    parameter int unsigned H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
    parameter int unsigned H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_SYNC_START = vga_timing_pkg::V_SYNC_START,
    parameter int unsigned V_SYNC_END   = vga_timing_pkg::V_SYNC_END,
    parameter int unsigned V_TOTAL      = vga_timing_pkg::V_TOTAL
) (
    input logic               clk,
    input logic               rst_n,
    vga_sync_decoder_if.slave bus
);

    import vga_timing_pkg::*;

    localparam vga_cnt_t HA     = vga_cnt_t'(H_ACTIVE);
    localparam vga_cnt_t HSS    = vga_cnt_t'(H_SYNC_START);
    localparam vga_cnt_t HSE    = vga_cnt_t'(H_SYNC_END);
    localparam vga_cnt_t H_LAST = vga_cnt_t'(H_TOTAL - 1);
    localparam vga_cnt_t VA     = vga_cnt_t'(V_ACTIVE);
    localparam vga_cnt_t VSS    = vga_cnt_t'(V_SYNC_START);
    localparam vga_cnt_t VSE    = vga_cnt_t'(V_SYNC_END);
    localparam vga_cnt_t V_LAST = vga_cnt_t'(V_TOTAL - 1);

    logic h_rise;
    logic h_fall;
    logic v_rise;
    logic v_fall;

    vga_lock_state_t state_q;
    vga_lock_state_t state_d;

    vga_cnt_t h_cnt;
    vga_cnt_t l_cnt;
    vga_cnt_t h_exp;
    vga_cnt_t l_exp;
    vga_cnt_t h_pos;
    vga_cnt_t l_pos;

    logic in_active;
    logic h_slot;
    logic hr_slot;
    logic v_slot;
    logic vr_slot;
    logic sync_bad;
    logic blank_bad;
    logic err;
    logic lock_d;

    logic valid_q;
    logic fs_q;
    logic err_q;

    vga_edge_detect u_h_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.hsync),
        .rise  (h_rise),
        .fall  (h_fall)
    );

    vga_edge_detect u_v_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.vsync),
        .rise  (v_rise),
        .fall  (v_fall)
    );

    // Position of the sample now on the inputs; sync falls realign it.
    always_comb begin
        h_exp = wrap_inc(h_cnt, H_LAST);
        l_exp = (h_cnt == H_LAST) ? wrap_inc(l_cnt, V_LAST) : l_cnt;
        h_pos = h_fall ? HSS : h_exp;
        l_pos = v_fall ? VSS : l_exp;
        in_active = (h_pos < HA) && (l_pos < VA);
    end

    always_comb begin
        h_slot    = (h_exp == HSS);
        hr_slot   = (h_exp == HSE);
        v_slot    = (h_exp == '0) && (l_exp == VSS);
        vr_slot   = (h_exp == '0) && (l_exp == VSE);
        sync_bad  = (h_slot != h_fall)
                 || (h_rise && !hr_slot)
                 || (v_slot != v_fall)
                 || (v_rise && !vr_slot);
        blank_bad = (bus.n_blank != in_active);
    end

    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (h_fall) begin
                    state_d = H_LOCK;
                end
            end
            H_LOCK: begin
                if (h_fall && !h_slot) begin
                    err = 1'b1;
                end else if (v_fall && (h_exp == '0)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                err = sync_bad || blank_bad;
                if (sync_bad) begin
                    state_d = H_LOCK;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign lock_d = (state_d == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            h_cnt   <= '0;
            l_cnt   <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt   <= h_pos;
            l_cnt   <= l_pos;
            valid_q <= lock_d && in_active;
            fs_q    <= lock_d && (h_pos == '0) && (l_pos == '0);
            err_q   <= err;
        end
    end

    assign bus.pixel_num   = h_cnt;
    assign bus.linea_num   = l_cnt;
    assign bus.pixel_valid = valid_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.frame_start = fs_q;
    assign bus.sync_error  = err_q;

endmodule
